// File: rtl/pixel_write_arbiter_pkg.sv
// pixel_write_arbiter_pkg: shared widths, default requester count and FSM encoding
package pixel_write_arbiter_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit above last, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index
);
    // Scan farthest-first so the nearest requester after last wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                onehot = '0;
                onehot[(int'(last) + k) % N] = 1'b1;
                index = IW'((int'(last) + k) % N);
            end
        end
    end
endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin ownership of the VGA write port among render engines
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [N_REQ-1:0]     pix_valid,
    input  logic [X_W*N_REQ-1:0] x_in,
    input  logic [Y_W*N_REQ-1:0] y_in,
    input  logic [C_W*N_REQ-1:0] colour_in,
    output logic [N_REQ-1:0]     grant,
    output logic [X_W-1:0]       x_vga,
    output logic [Y_W-1:0]       y_vga,
    output logic [C_W-1:0]       colour_vga,
    output logic                 writeEn,
    output logic                 busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, pick_oh;
    logic [IW-1:0]    last_q, last_d, pick_idx, gidx;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             we_q, we_d;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .last   (last_q),
        .onehot (pick_oh),
        .index  (pick_idx)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) gidx = IW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick_oh;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // The pixel presented with done is still captured this cycle.
                x_d  = x_in[int'(gidx)*X_W +: X_W];
                y_d  = y_in[int'(gidx)*Y_W +: Y_W];
                c_d  = colour_in[int'(gidx)*C_W +: C_W];
                we_d = pix_valid[gidx];
                if (done[gidx] || !req[gidx]) begin
                    last_d  = gidx;
                    grant_d = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            we_q    <= we_d;
        end
    end

    assign grant      = grant_q;
    assign x_vga      = x_q;
    assign y_vga      = y_q;
    assign colour_vga = c_q;
    assign writeEn    = we_q;
    assign busy       = (state_q == GRANT) || (state_q == RELEASE);
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter: random and directed stimulus scored against an ownership-level model
module tb_pixel_write_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [3:0] g;
        logic       b;
        logic       we;
        logic       rc;
    } rec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0, done = '0, pix_valid = '0;
    logic [31:0] x_in = '0;
    logic [27:0] y_in = '0;
    logic [11:0] colour_in = '0;
    logic [3:0]  grant;
    logic [7:0]  x_vga;
    logic [6:0]  y_vga;
    logic [2:0]  colour_vga;
    logic        writeEn, busy;

    rec_t        cq[$];
    logic [17:0] pq[$];
    int          total = 0;
    int          passed = 0;

    pixel_write_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .done       (done),
        .pix_valid  (pix_valid),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .grant      (grant),
        .x_vga      (x_vga),
        .y_vga      (y_vga),
        .colour_vga (colour_vga),
        .writeEn    (writeEn),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int a, int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endfunction

    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] p,
                        input logic rn = 1'b1, input int pe = -1,
                        input logic [7:0] px = '0, input logic [6:0] py = '0,
                        input logic [2:0] pc = '0);
        req       = r;
        done      = d;
        pix_valid = p;
        resetn    = rn;
        x_in      = $urandom;
        y_in      = 28'($urandom);
        colour_in = 12'($urandom);
        if (pe >= 0) begin
            x_in[pe*8 +: 8]      = px;
            y_in[pe*7 +: 7]      = py;
            colour_in[pe*3 +: 3] = pc;
        end
        @(posedge clk);
        #2;
    endtask

    // Reference: who owns the port, whether the one-cycle release gap is pending, who went last.
    initial begin
        int owner, gap, last;
        rec_t r;
        owner = -1;
        gap   = 0;
        last  = N - 1;
        forever begin
            @(posedge clk);
            r.we = 1'b0;
            r.rc = 1'b0;
            if (!resetn) begin
                owner = -1;
                gap   = 0;
                last  = N - 1;
                r.rc  = 1'b1;
            end else if (owner >= 0) begin
                if (pix_valid[owner]) begin
                    r.we = 1'b1;
                    pq.push_back({x_in[owner*8 +: 8], y_in[owner*7 +: 7], colour_in[owner*3 +: 3]});
                end
                if (done[owner] || !req[owner]) begin
                    last  = owner;
                    owner = -1;
                    gap   = 1;
                end
            end else if (gap != 0) begin
                gap = 0;
            end else if (req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req[(last + k) % N]) begin
                        owner = (last + k) % N;
                        break;
                    end
                end
            end
            r.g = (owner >= 0) ? 4'(1 << owner) : 4'b0;
            r.b = (owner >= 0) || (gap != 0);
            cq.push_back(r);
        end
    end

    initial begin
        rec_t e;
        logic [17:0] p;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("grant", int'(grant), int'(e.g));
                chk("busy", int'(busy), int'(e.b));
                chk("writeEn", int'(writeEn), int'(e.we));
                if (e.rc) begin
                    chk("rst_x", int'(x_vga), 0);
                    chk("rst_y", int'(y_vga), 0);
                    chk("rst_c", int'(colour_vga), 0);
                end
                if (e.we && writeEn) begin
                    if (pq.size() == 0) chk("pix_avail", pq.size(), 1);
                    else begin
                        p = pq.pop_front();
                        chk("x_vga", int'(x_vga), int'(p[17:10]));
                        chk("y_vga", int'(y_vga), int'(p[9:3]));
                        chk("colour_vga", int'(colour_vga), int'(p[2:0]));
                    end
                end else if (e.we) begin
                    void'(pq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] rr;
        step(4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        // single requester, three pixels then done
        step(4'b0001, 4'h0, 4'h0);
        repeat (3) step(4'b0001, 4'h0, 4'b0001, 1'b1, 0, 8'd10, 7'd20, 3'd4);
        step(4'b0001, 4'b0001, 4'h0);
        repeat (3) step(4'h0, 4'h0, 4'h0);
        // all engines requesting, 2-pixel bursts
        repeat (5) begin
            step(4'hF, 4'h0, 4'h0);
            step(4'hF, 4'h0, 4'hF);
            step(4'hF, 4'hF, 4'hF);
            step(4'hF, 4'h0, 4'h0);
        end
        // engine 1 chatters while engine 2 owns the port
        step(4'b0100, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++)
            step(4'b0100, 4'h0, (i % 2) ? 4'b0110 : 4'b0100, 1'b1, 1, 8'd99, 7'd99, 3'd7);
        step(4'b0100, 4'b0100, 4'h0);
        repeat (2) step(4'h0, 4'h0, 4'h0);
        // engine 3 drops req without done
        step(4'b1000, 4'h0, 4'h0);
        step(4'b1000, 4'h0, 4'b1000);
        repeat (3) step(4'b0001, 4'h0, 4'h0);
        step(4'b0001, 4'b0001, 4'h0);
        repeat (2) step(4'h0, 4'h0, 4'h0);
        // reset in the middle of a burst
        step(4'b0001, 4'h0, 4'h0);
        step(4'b0001, 4'h0, 4'b0001);
        step(4'b0001, 4'h0, 4'b0001, 1'b0);
        step(4'b0100, 4'h0, 4'h0);
        step(4'b0100, 4'h0, 4'b0100);
        step(4'b0100, 4'b0100, 4'h0);
        repeat (2) step(4'h0, 4'h0, 4'h0);
        // pixel coinciding with done
        step(4'b0001, 4'h0, 4'h0);
        step(4'b0001, 4'b0001, 4'b0001, 1'b1, 0, 8'd159, 7'd119, 3'd2);
        repeat (3) step(4'h0, 4'h0, 4'h0);
        rr = '0;
        repeat (3000) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            step(rr, 4'($urandom & $urandom), 4'($urandom), 1'($urandom_range(0, 99) != 0));
        end
        repeat (4) step(4'h0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        chk("cq_drained", cq.size(), 0);
        chk("pq_drained", pq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
